// File: rtl/risc_pkg.sv
// Shared opcode values, FSM state encoding and instruction-field width rules
// for the parametrised RISC core and its ALU.
package risc_pkg;

    localparam int OP_NOP  = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_NOT  = 4;
    localparam int OP_RD   = 5;
    localparam int OP_WR   = 6;
    localparam int OP_BR   = 7;
    localparam int OP_BRZ  = 8;
    localparam int OP_HALT = 15;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_FETCH_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_HALT
    } state_t;

    // A single-register file still needs a one-bit index field.
    function automatic int ridx_width(input int reg_cnt);
        return (reg_cnt > 1) ? $clog2(reg_cnt) : 1;
    endfunction

    function automatic bit fields_fit(input int word_w, input int op_w, input int ridx_w);
        return (op_w + 2 * ridx_w) <= word_w;
    endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU for the RISC core: ADD/SUB/AND/NOT with zero and carry/borrow.
module risc_alu
    import risc_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int OP_W   = 4
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [WORD_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [WORD_W:0] sum;

    // a is the destination operand, b the source; SUB carry is the unsigned borrow.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        sum    = '0;
        case (int'(op))
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[WORD_W-1:0];
                carry  = sum[WORD_W];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND:  result = a & b;
            OP_NOT:  result = ~b;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/risc_core_param.sv
// Multi-cycle RISC core: register file, PC/IR/AR, flags and a fetch/decode/execute
// FSM talking to a unified memory over a req/ack handshake.
module risc_core_param
    import risc_pkg::*;
#(
    parameter  int WORD_W  = 8,
    parameter  int OP_W    = 4,
    parameter  int REG_CNT = 4,
    localparam int RIDX_W  = ridx_width(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              zflag,
    output logic              cflag,
    output logic              illegal_op,
    output logic [WORD_W-1:0] pc_out,
    input  logic [RIDX_W-1:0] dbg_sel,
    output logic [WORD_W-1:0] dbg_data
);

    if (!fields_fit(WORD_W, OP_W, RIDX_W)) begin : g_bad_fields
        $error("risc_core_param: OP_W + 2*RIDX_W exceeds WORD_W");
    end

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] ar;
    logic [WORD_W-1:0] regs [REG_CNT];
    logic [WORD_W-1:0] pc_inc;
    logic [OP_W-1:0]   opcode;
    logic [RIDX_W-1:0] src;
    logic [RIDX_W-1:0] dst;
    int                op_i;
    logic              alu_wr;
    logic [WORD_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;

    assign opcode   = ir[WORD_W-1 -: OP_W];
    assign src      = ir[WORD_W-OP_W-1 -: RIDX_W];
    assign dst      = ir[WORD_W-OP_W-RIDX_W-1 -: RIDX_W];
    assign op_i     = int'(opcode);
    assign pc_inc   = pc + WORD_W'(1);
    assign pc_out   = pc;
    assign dbg_data = regs[dbg_sel];

    risc_alu #(
        .WORD_W (WORD_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a      (regs[dst]),
        .b      (regs[src]),
        .op     (opcode),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Requests are gated by rst so an abort drops mem_req without waiting for a clock.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc;
        mem_wdata  = '0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        alu_wr     = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req = rst;
                if (mem_ack) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (op_i)
                    OP_NOP: state_next = ST_FETCH;
                    OP_ADD, OP_SUB, OP_AND, OP_NOT: begin
                        alu_wr     = 1'b1;
                        state_next = ST_FETCH;
                    end
                    OP_RD, OP_WR, OP_BR, OP_BRZ: state_next = ST_FETCH_ADDR;
                    OP_HALT: state_next = ST_HALT;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = ST_FETCH;
                    end
                endcase
            end
            ST_FETCH_ADDR: begin
                mem_req = rst;
                if (mem_ack) begin
                    case (op_i)
                        OP_RD:   state_next = ST_MEM_RD;
                        OP_WR:   state_next = ST_MEM_WR;
                        default: state_next = ST_FETCH;
                    endcase
                end
            end
            ST_MEM_RD: begin
                mem_req  = rst;
                mem_addr = ar;
                if (mem_ack) state_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_req   = rst;
                mem_we    = rst;
                mem_addr  = ar;
                mem_wdata = regs[src];
                if (mem_ack) state_next = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_next = ST_FETCH;
        endcase
    end

    // Branch targets come straight from the address word so the next fetch uses them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= '0;
            ir    <= '0;
            ar    <= '0;
            zflag <= 1'b0;
            cflag <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc_inc;
                    end
                end
                ST_DECODE: begin
                    if (alu_wr) begin
                        regs[dst] <= alu_result;
                        zflag     <= alu_zero;
                        cflag     <= alu_carry;
                    end
                end
                ST_FETCH_ADDR: begin
                    if (mem_ack) begin
                        ar <= mem_rdata;
                        if (op_i == OP_BR || (op_i == OP_BRZ && zflag)) pc <= mem_rdata;
                        else pc <= pc_inc;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ack) regs[dst] <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule
